vector_stream_reader: RTL and testbench

//  Streams whole vectors out of a synchronous element RAM. Successor to the fixed single-cycle vector constructor.

---
 rtl/vector_stream_reader_if.sv | 24 ++
 rtl/vector_stream_reader.sv | 153 +++++++++++++++
 tb/tb_vector_stream_reader.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_stream_reader_if.sv
// Operand-RAM read port plus the assembled-vector output stream of vector_stream_reader.
// master = the reader, slave = RAM/consumer side.
interface vector_stream_reader_if #(
    parameter int ELEMENT_WIDTH    = 24,
    parameter int ADDR_WIDTH       = 17,
    parameter int VECTOR_DIMENSION = 3
);
    logic [ADDR_WIDTH-1:0]                     ram_addr;
    logic                                      ram_en;
    logic [ELEMENT_WIDTH-1:0]                  ram_data;
    logic [VECTOR_DIMENSION*ELEMENT_WIDTH-1:0] vector_out;
    logic                                      vector_valid;
    logic                                      vector_ready;

    modport master (
        output ram_addr, ram_en, vector_out, vector_valid,
        input  ram_data, vector_ready
    );

    modport slave (
        input  ram_addr, ram_en, vector_out, vector_valid,
        output ram_data, vector_ready
    );
endinterface

// File: rtl/vector_stream_reader.sv
// Streams num_vectors whole vectors out of a synchronous element RAM starting at base_addr,
// with credit-limited reads, an assembly register and a valid/ready output register.
module vector_stream_reader #(
    parameter int ELEMENT_WIDTH    = 24,
    parameter int ADDR_WIDTH       = 17,
    parameter int VECTOR_DIMENSION = 3,
    parameter int READ_LATENCY     = 1,
    parameter int VCOUNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [VCOUNT_WIDTH-1:0] num_vectors,
    output logic                    busy,
    output logic                    done,
    output logic [VCOUNT_WIDTH-1:0] vectors_sent,
    vector_stream_reader_if.master  bus
);
    localparam int FW = $clog2(VECTOR_DIMENSION + 1);
    localparam int CW = VCOUNT_WIDTH + FW;
    localparam int VW = VECTOR_DIMENSION * ELEMENT_WIDTH;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state_reg, state_next;
    logic   done_reg, done_next;

    logic [ADDR_WIDTH-1:0]    base_reg;
    logic [VCOUNT_WIDTH-1:0]  num_reg, sent_reg;
    logic [CW-1:0]            total_reg, issued_reg;
    logic [FW-1:0]            fill_reg, in_flight_reg;
    logic [READ_LATENCY-1:0]  pipe_reg, pipe_next;
    logic [ELEMENT_WIDTH-1:0] asm_reg [VECTOR_DIMENSION];
    logic [VW-1:0]            out_reg, assembled;
    logic                     out_valid_reg;

    logic start_job, flush, issue, ret, hs, last_hs, vec_complete, load_out;

    assign start_job = (state_reg == IDLE) && start && !abort;
    assign flush     = (state_reg == RUN) && abort;
    assign ret       = pipe_reg[READ_LATENCY-1];
    assign hs        = out_valid_reg && bus.vector_ready;
    assign last_hs   = hs && (({1'b0, sent_reg} + (VCOUNT_WIDTH+1)'(1)) == {1'b0, num_reg});

    // Credit rule: never have more elements outstanding than the assembly register can absorb.
    assign issue = (state_reg == RUN) && (issued_reg < total_reg) &&
                   (({1'b0, in_flight_reg} + {1'b0, fill_reg}) < (FW+1)'(VECTOR_DIMENSION));

    assign vec_complete = (ret && (fill_reg == FW'(VECTOR_DIMENSION - 1))) ||
                          (fill_reg == FW'(VECTOR_DIMENSION));
    assign load_out     = vec_complete && (!out_valid_reg || hs);

    if (READ_LATENCY == 1) begin : g_pipe_single
        assign pipe_next = issue;
    end else begin : g_pipe_multi
        assign pipe_next = {pipe_reg[READ_LATENCY-2:0], issue};
    end

    // The returning element bypasses straight into its slot so the final element can move out this edge.
    for (genvar gi = 0; gi < VECTOR_DIMENSION; gi++) begin : g_slot
        assign assembled[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
            (ret && (fill_reg == FW'(gi))) ? bus.ram_data : asm_reg[gi];
    end

    assign bus.ram_en       = issue;
    assign bus.ram_addr     = base_reg + ADDR_WIDTH'(issued_reg);
    assign bus.vector_out   = out_reg;
    assign bus.vector_valid = out_valid_reg;
    assign busy             = (state_reg == RUN);
    assign done             = done_reg;
    assign vectors_sent     = sent_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_job) begin
                    if (num_vectors == '0) done_next  = 1'b1;
                    else                   state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_hs) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_reg      <= '0;
            num_reg       <= '0;
            total_reg     <= '0;
            issued_reg    <= '0;
            fill_reg      <= '0;
            in_flight_reg <= '0;
            sent_reg      <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            pipe_reg      <= '0;
            for (int k = 0; k < VECTOR_DIMENSION; k++) asm_reg[k] <= '0;
        end else if (start_job) begin
            base_reg      <= base_addr;
            num_reg       <= num_vectors;
            total_reg     <= CW'(num_vectors) * CW'(VECTOR_DIMENSION);
            issued_reg    <= '0;
            fill_reg      <= '0;
            in_flight_reg <= '0;
            sent_reg      <= '0;
            out_valid_reg <= 1'b0;
            pipe_reg      <= '0;
        end else if (flush) begin
            fill_reg      <= '0;
            in_flight_reg <= '0;
            out_valid_reg <= 1'b0;
            pipe_reg      <= '0;
            if (hs) sent_reg <= sent_reg + VCOUNT_WIDTH'(1);
        end else begin
            pipe_reg      <= pipe_next;
            in_flight_reg <= in_flight_reg + FW'(issue) - FW'(ret);
            if (issue) issued_reg <= issued_reg + CW'(1);
            if (load_out)  fill_reg <= '0;
            else if (ret)  fill_reg <= fill_reg + FW'(1);
            for (int k = 0; k < VECTOR_DIMENSION; k++) begin
                if (ret && (fill_reg == FW'(k))) asm_reg[k] <= bus.ram_data;
            end
            if (load_out) begin
                out_reg       <= assembled;
                out_valid_reg <= 1'b1;
            end else if (hs) begin
                out_valid_reg <= 1'b0;
            end
            if (hs) sent_reg <= sent_reg + VCOUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_vector_stream_reader.sv
// Directed + randomized bench for vector_stream_reader: one D=3/L=1 instance and one D=4/L=3 instance,
// each fed by a behavioural RAM, with expected vectors derived from base/index arithmetic.
module tb_vector_stream_reader;
    localparam int EW  = 24;
    localparam int AW  = 17;
    localparam int VCW = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failures = 0;

    vector_stream_reader_if #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(3)) a_if ();
    vector_stream_reader_if #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(4)) b_if ();

    logic a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b0, a_busy, a_done;
    logic b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b0, b_busy, b_done;
    logic [AW-1:0]  a_base = '0, b_base = '0;
    logic [VCW-1:0] a_num = '0, b_num = '0, a_sent, b_sent;
    logic b_rand = 1'b0;

    vector_stream_reader #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(3),
                           .READ_LATENCY(1), .VCOUNT_WIDTH(VCW)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort), .base_addr(a_base),
        .num_vectors(a_num), .busy(a_busy), .done(a_done), .vectors_sent(a_sent), .bus(a_if));

    vector_stream_reader #(.ELEMENT_WIDTH(EW), .ADDR_WIDTH(AW), .VECTOR_DIMENSION(4),
                           .READ_LATENCY(3), .VCOUNT_WIDTH(VCW)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort), .base_addr(b_base),
        .num_vectors(b_num), .busy(b_busy), .done(b_done), .vectors_sent(b_sent), .bus(b_if));

    // RAM contents: instance a holds addr+1, instance b holds addr*5+7.
    function automatic logic [EW-1:0] ram_val(input bit is_b, input logic [AW-1:0] ad);
        if (is_b) return EW'({7'd0, ad} * 24'd5 + 24'd7);
        return EW'({7'd0, ad}) + 24'd1;
    endfunction

    logic [EW-1:0] a_rd = '0;
    logic [EW-1:0] b_pipe [3];
    always @(posedge clk) a_rd <= a_if.ram_en ? ram_val(1'b0, a_if.ram_addr) : '0;
    always @(posedge clk) begin
        b_pipe[0] <= b_if.ram_en ? ram_val(1'b1, b_if.ram_addr) : '0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_if.ram_data     = a_rd;
    assign b_if.ram_data     = b_pipe[2];
    assign a_if.vector_ready = a_ready;
    assign b_if.vector_ready = b_ready;

    logic           m_en [2], m_valid [2], m_ready [2], m_done [2], m_busy [2];
    logic [AW-1:0]  m_addr [2];
    logic [VCW-1:0] m_sent [2];
    logic [127:0]   m_vec [2];
    assign m_en[0] = a_if.ram_en;          assign m_en[1] = b_if.ram_en;
    assign m_valid[0] = a_if.vector_valid; assign m_valid[1] = b_if.vector_valid;
    assign m_ready[0] = a_ready;           assign m_ready[1] = b_ready;
    assign m_done[0] = a_done;             assign m_done[1] = b_done;
    assign m_busy[0] = a_busy;             assign m_busy[1] = b_busy;
    assign m_addr[0] = a_if.ram_addr;      assign m_addr[1] = b_if.ram_addr;
    assign m_sent[0] = a_sent;             assign m_sent[1] = b_sent;
    assign m_vec[0] = 128'(a_if.vector_out);
    assign m_vec[1] = 128'(b_if.vector_out);

    int           reads [2], nvec [2], done_cnt [2], done_cyc [2], first_valid [2], unstable [2], start_cyc [2];
    logic [127:0] vecs [2][16];
    int           hs_cyc [2][16];
    logic [AW-1:0] addrs [2][64];
    logic         prev_v [2], prev_r [2];
    logic [127:0] prev_vec [2];

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!reset_n) begin
                prev_v[s] = 1'b0;
            end else begin
                if (m_en[s]) begin
                    if (reads[s] < 64) addrs[s][reads[s]] = m_addr[s];
                    reads[s]++;
                end
                if (m_valid[s] && m_ready[s]) begin
                    if (nvec[s] < 16) begin
                        vecs[s][nvec[s]]   = m_vec[s];
                        hs_cyc[s][nvec[s]] = cyc;
                    end
                    nvec[s]++;
                    $display("[TB] dut%0d vector %0d accepted at cycle %0d: %h", s, nvec[s], cyc, m_vec[s]);
                end
                if (m_valid[s] && first_valid[s] < 0) first_valid[s] = cyc;
                if (m_done[s]) begin
                    done_cnt[s]++;
                    done_cyc[s] = cyc;
                end
                if (prev_v[s] && !prev_r[s] && !(m_valid[s] && m_vec[s] === prev_vec[s])) unstable[s]++;
                prev_v[s]   = m_valid[s];
                prev_r[s]   = m_ready[s];
                prev_vec[s] = m_vec[s];
            end
        end
    end

    function automatic logic [127:0] exp_vec(input int s, input int dim, input logic [AW-1:0] base, input int j);
        logic [127:0]  r;
        logic [AW-1:0] ad;
        r = '0;
        for (int k = 0; k < dim; k++) begin
            ad = base + AW'(j * dim + k);
            r[k*EW +: EW] = ram_val(s == 1, ad);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear(input int s);
        reads[s] = 0; nvec[s] = 0; done_cnt[s] = 0; done_cyc[s] = -1;
        first_valid[s] = -1; unstable[s] = 0;
    endtask

    task automatic start_job(input int s, input logic [AW-1:0] base, input logic [VCW-1:0] n);
        clear(s);
        if (s == 0) begin a_base = base; a_num = n; a_start = 1'b1; end
        else        begin b_base = base; b_num = n; b_start = 1'b1; end
        start_cyc[s] = cyc;
        tick(1);
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic wait_done(input int s, input int tmo, input string tag);
        int t = 0;
        while (done_cnt[s] == 0 && t < tmo) begin
            tick(1);
            t++;
        end
        check({tag, "_done_seen"}, done_cnt[s] > 0, 1'b1);
        tick(2);
    endtask

    task automatic wait_valid(input int s, input int tmo, input string tag);
        int t = 0;
        while (!m_valid[s] && t < tmo) begin
            tick(1);
            t++;
        end
        check({tag, "_valid_seen"}, m_valid[s], 1'b1);
    endtask

    task automatic check_job(input int s, input string tag, input logic [AW-1:0] base,
                             input int n, input int dim, input int lat);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_vec%0d", tag, i), vecs[s][i], exp_vec(s, dim, base, i));
        check({tag, "_count"}, nvec[s], n);
        check({tag, "_sent"}, m_sent[s], VCW'(n));
        check({tag, "_done_once"}, done_cnt[s], 1);
        check({tag, "_done_cycle"}, done_cyc[s], hs_cyc[s][n-1] + 1);
        check({tag, "_reads"}, reads[s], n * dim);
        check({tag, "_latency"}, first_valid[s] - start_cyc[s], lat);
        check({tag, "_stable"}, unstable[s], 0);
        check({tag, "_busy_low"}, m_busy[s], 1'b0);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (b_rand) b_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0]  bb;
        logic [VCW-1:0] nn;
        clear(0);
        clear(1);
        tick(2);
        check("rst_ram_en", a_if.ram_en, 1'b0);
        check("rst_ram_addr", a_if.ram_addr, '0);
        check("rst_valid", a_if.vector_valid, 1'b0);
        check("rst_vector_out", a_if.vector_out, '0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_sent", a_sent, '0);
        check("rst_b_valid", b_if.vector_valid, 1'b0);
        check("rst_b_busy", b_busy, 1'b0);
        reset_n = 1'b1;
        tick(2);

        // Two vectors, free-running consumer.
        a_ready = 1'b1;
        start_job(0, '0, 16'd2);
        wait_done(0, 60, "t1");
        check("t1_literal_vec0", vecs[0][0], {24'd3, 24'd2, 24'd1});
        check("t1_rate", hs_cyc[0][1] - hs_cyc[0][0], 4);
        check_job(0, "t1", '0, 2, 3, 5);

        // Consumer stalls for 10 cycles at the first valid vector.
        a_ready = 1'b0;
        start_job(0, 17'd100, 16'd3);
        wait_valid(0, 40, "t2");
        tick(10);
        check("t2_stall_reads", reads[0], 6);
        check("t2_stall_valid", a_if.vector_valid, 1'b1);
        check("t2_stall_vec", a_if.vector_out, exp_vec(0, 3, 17'd100, 0));
        a_ready = 1'b1;
        wait_done(0, 80, "t2");
        check_job(0, "t2", 17'd100, 3, 3, 5);

        // Address wrap at the top of the RAM.
        start_job(0, 17'h1FFFE, 16'd1);
        wait_done(0, 60, "t3");
        check("t3_addr0", addrs[0][0], 17'h1FFFE);
        check("t3_addr1", addrs[0][1], 17'h1FFFF);
        check("t3_addr2", addrs[0][2], 17'h00000);
        check_job(0, "t3", 17'h1FFFE, 1, 3, 5);

        // Empty job.
        start_job(0, 17'd5, 16'd0);
        check("t5_zero_done", a_done, 1'b1);
        check("t5_zero_busy", a_busy, 1'b0);
        tick(3);
        check("t5_zero_reads", reads[0], 0);
        check("t5_zero_done_once", done_cnt[0], 1);

        // Abort after the first vector.
        start_job(0, 17'd40, 16'd3);
        for (int t = 0; t < 40 && nvec[0] == 0; t++) tick(1);
        a_abort = 1'b1;
        tick(1);
        a_abort = 1'b0;
        check("t5_abort_valid", a_if.vector_valid, 1'b0);
        check("t5_abort_busy", a_busy, 1'b0);
        check("t5_abort_ram_en", a_if.ram_en, 1'b0);
        tick(6);
        check("t5_abort_no_done", done_cnt[0], 0);
        check("t5_abort_sent", a_sent, 16'd1);
        check("t5_abort_vec0", vecs[0][0], exp_vec(0, 3, 17'd40, 0));

        // abort together with start: nothing starts.
        a_abort = 1'b1;
        start_job(0, '0, 16'd2);
        a_abort = 1'b0;
        tick(8);
        check("t5_abs_busy", a_busy, 1'b0);
        check("t5_abs_reads", reads[0], 0);
        check("t5_abs_done", done_cnt[0], 0);
        check("t5_abs_sent", a_sent, 16'd1);

        // Reset mid-job with a vector waiting.
        a_ready = 1'b0;
        start_job(0, 17'd7, 16'd3);
        wait_valid(0, 40, "t6");
        tick(2);
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", a_if.vector_valid, 1'b0);
        check("t6_rst_busy", a_busy, 1'b0);
        check("t6_rst_sent", a_sent, '0);
        check("t6_rst_vector_out", a_if.vector_out, '0);
        check("t6_rst_ram_addr", a_if.ram_addr, '0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        a_ready = 1'b1;
        start_job(0, '0, 16'd2);
        wait_done(0, 60, "t6");
        check_job(0, "t6", '0, 2, 3, 5);

        // Wide, deep instance with random back-pressure and random bases.
        b_rand = 1'b1;
        for (int j = 0; j < 3; j++) begin
            nn = (j == 0) ? 16'd3 : VCW'($urandom_range(1, 4));
            bb = (j == 2) ? AW'(32'h1FFFF - $urandom_range(0, 6)) : AW'($urandom_range(0, 32'h1FFFF));
            start_job(1, bb, nn);
            wait_done(1, 600, $sformatf("b%0d", j));
            check_job(1, $sformatf("b%0d", j), bb, int'(nn), 4, 8);
        end
        b_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
